corr_window_ctrl: RTL and testbench

Sequencer for the logdrop correlation counter datapath (x/y/isect/symdiff counters).
- Generates the window time index, the zero-counts pulse, the clock-gate enable and the window-length exponent that the datapath consumes.
- Snapshots the four datapath counts at each window boundary into a single-entry result register with a valid/ready handshake toward the software-visible register block.

---
 rtl/corr_pkg.sv | 27 ++
 rtl/corr_window_timer.sv | 49 ++++
 rtl/corr_window_ctrl.sv | 164 ++++++++++++++++
 tb/tb_corr_window_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// Shared types and helpers for the correlation-window sequencer.
//   state_t   : sequencer states IDLE / START / RUN / FINAL
//   cnt_w     : width of a datapath count for a given time and increment width
//   exp_w     : width needed to hold a window-length exponent 0..time_w
//   clamp_exp : limits a requested exponent to the time-index precision
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    FINAL = 2'd3
  } state_t;

  function automatic int cnt_w(input int time_w, input int incr_w);
    return time_w + incr_w - 1;
  endfunction

  function automatic int exp_w(input int time_w);
    return $clog2(time_w + 1);
  endfunction

  function automatic int clamp_exp(input int e, input int time_w);
    return (e > time_w) ? time_w : e;
  endfunction

endpackage

// File: rtl/corr_window_timer.sv
// Window time-index counter for the correlation sequencer.
// Holds the latched (clamped) window-length exponent and the running time
// index t, which wraps from last = 2**exp - 1 back to 0.
//   clk, rst  : clock, synchronous active-high reset
//   load      : latch exp_req (clamped) and restart t at 0
//   step      : advance t by one, wrapping at the window end
//   exp_req   : requested exponent
//   t         : current time index
//   len_exp   : latched, clamped exponent
//   is_first  : t == 0
//   is_last   : t == last
module corr_window_timer
  import corr_pkg::*;
#(
  parameter int TIME_W = 8,
  localparam int EXP_W = exp_w(TIME_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [EXP_W-1:0]  exp_req,
  output logic [TIME_W-1:0] t,
  output logic [EXP_W-1:0]  len_exp,
  output logic              is_first,
  output logic              is_last
);

  logic [TIME_W-1:0] last;

  // A low-bit mask equals 2**exp - 1; exp == TIME_W shifts every one out,
  // giving an all-ones mask for the full-length window.
  assign last     = ~({TIME_W{1'b1}} << len_exp);
  assign is_first = (t == '0);
  assign is_last  = (t == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      t       <= '0;
      len_exp <= '0;
    end else if (load) begin
      len_exp <= EXP_W'(clamp_exp(int'(exp_req), TIME_W));
      t       <= '0;
    end else if (step) begin
      t <= is_last ? '0 : t + 1'b1;
    end
  end

endmodule

// File: rtl/corr_window_ctrl.sv
// Sequencer for the logdrop correlation counter datapath.
// Drives the window time index, zero-counts pulse, clock-gate enable and
// window-length exponent, and snapshots the four datapath counts at every
// window boundary into a single-entry result register (valid/ready).
// Optional feature: define CORR_WINDOW_CTRL_DROPCOUNT_EN to add o_nDropped,
// a saturating count of snapshots lost because the result was not consumed.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_enable                : run windows back to back while high
//   i_windowLengthExp       : requested exponent, latched when leaving IDLE
//   o_busy                  : high outside IDLE
//   o_dpCg                  : datapath clock-gate enable
//   o_dpT                   : window time index
//   o_dpZeroCounts          : first cycle of a window
//   o_dpWindowLengthExp     : latched, clamped exponent
//   i_dpCount*              : datapath counts (x, y, isect, symdiff)
//   o_rsltValid/i_rsltReady : result handshake
//   o_rsltCount*, o_rsltSeq : snapshot and its window sequence number
//   o_nDropped              : dropped-snapshot count (optional)
module corr_window_ctrl
  import corr_pkg::*;
#(
  parameter int TIME_W = 8,
  parameter int INCR_W = 16,
  parameter int SEQ_W  = 8,
  parameter int DROP_W = 8,
  localparam int CNT_W = cnt_w(TIME_W, INCR_W),
  localparam int EXP_W = exp_w(TIME_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [EXP_W-1:0]  i_windowLengthExp,
  output logic              o_busy,
  output logic              o_dpCg,
  output logic [TIME_W-1:0] o_dpT,
  output logic              o_dpZeroCounts,
  output logic [EXP_W-1:0]  o_dpWindowLengthExp,
  input  logic [CNT_W-1:0]  i_dpCountX,
  input  logic [CNT_W-1:0]  i_dpCountY,
  input  logic [CNT_W-1:0]  i_dpCountIsect,
  input  logic [CNT_W-1:0]  i_dpCountSymdiff,
  output logic              o_rsltValid,
  input  logic              i_rsltReady,
  output logic [CNT_W-1:0]  o_rsltCountX,
  output logic [CNT_W-1:0]  o_rsltCountY,
  output logic [CNT_W-1:0]  o_rsltCountIsect,
  output logic [CNT_W-1:0]  o_rsltCountSymdiff,
  output logic [SEQ_W-1:0]  o_rsltSeq
`ifdef CORR_WINDOW_CTRL_DROPCOUNT_EN
  ,
  output logic [DROP_W-1:0] o_nDropped
`endif
);

  if (DROP_W < 1 || SEQ_W < 1) begin : g_param_check
    $error("corr_window_ctrl: DROP_W and SEQ_W must be at least 1");
  end

  state_t state, state_nxt;

  logic busy_nxt, cg_nxt, zc_nxt;
  logic tmr_load, tmr_step;
  logic is_first, is_last;
  logic snap_p0;
  logic xfer, accept;
  logic [SEQ_W-1:0] seq_cnt;

  corr_window_timer #(
    .TIME_W (TIME_W)
  ) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (tmr_load),
    .step     (tmr_step),
    .exp_req  (i_windowLengthExp),
    .t        (o_dpT),
    .len_exp  (o_dpWindowLengthExp),
    .is_first (is_first),
    .is_last  (is_last)
  );

  // State register; the datapath controls are registered alongside so every
  // output is a flop that reflects the state it belongs to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      o_busy         <= 1'b0;
      o_dpCg         <= 1'b0;
      o_dpZeroCounts <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_busy         <= busy_nxt;
      o_dpCg         <= cg_nxt;
      o_dpZeroCounts <= zc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_enable) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (is_last && !i_enable) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are computed for the state being entered. The index
  // lands on 0 in RUN exactly when the current cycle is the window's last
  // (this also covers START -> RUN for a one-cycle window).
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    cg_nxt   = (state_nxt == START) || (state_nxt == RUN);
    zc_nxt   = (state_nxt == START) || ((state_nxt == RUN) && is_last);
    tmr_load = (state == IDLE) && (state_nxt == START);
    tmr_step = (state == START) || (state == RUN);
    snap_p0  = ((state == RUN) && is_first) || (state == FINAL);
  end

  assign xfer   = o_rsltValid && i_rsltReady;
  // A snapshot lands if the slot is empty or is being emptied this cycle;
  // otherwise the held result wins and the new one is lost.
  assign accept = snap_p0 && (!o_rsltValid || i_rsltReady);

  // Snapshot stage: result register and window sequence counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seq_cnt            <= '0;
      o_rsltValid        <= 1'b0;
      o_rsltSeq          <= '0;
      o_rsltCountX       <= '0;
      o_rsltCountY       <= '0;
      o_rsltCountIsect   <= '0;
      o_rsltCountSymdiff <= '0;
    end else begin
      if (snap_p0) seq_cnt <= seq_cnt + 1'b1;
      if (accept) begin
        o_rsltValid        <= 1'b1;
        o_rsltSeq          <= seq_cnt;
        o_rsltCountX       <= i_dpCountX;
        o_rsltCountY       <= i_dpCountY;
        o_rsltCountIsect   <= i_dpCountIsect;
        o_rsltCountSymdiff <= i_dpCountSymdiff;
      end else if (xfer) begin
        o_rsltValid <= 1'b0;
      end
    end
  end

`ifdef CORR_WINDOW_CTRL_DROPCOUNT_EN
  logic drop;
  assign drop = snap_p0 && o_rsltValid && !i_rsltReady;

  always_ff @(posedge i_clk) begin
    if (i_rst || tmr_load) begin
      o_nDropped <= '0;
    end else if (drop && (o_nDropped != '1)) begin
      o_nDropped <= o_nDropped + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_corr_window_ctrl.sv
module tb_corr_window_ctrl;
  localparam int TIME_W = 4;
  localparam int INCR_W = 4;
  localparam int SEQ_W  = 8;
  localparam int DROP_W = 8;
  localparam int CNT_W  = TIME_W + INCR_W - 1;
  localparam int EXP_W  = $clog2(TIME_W + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [EXP_W-1:0]  wexp;
  logic              busy, cg, zc;
  logic [TIME_W-1:0] t;
  logic [EXP_W-1:0]  dpexp;
  logic [CNT_W-1:0]  cx, cy, ci, cs;
  logic              valid, ready;
  logic [CNT_W-1:0]  rx, ry, ri, rs;
  logic [SEQ_W-1:0]  seq;
`ifdef CORR_WINDOW_CTRL_DROPCOUNT_EN
  logic [DROP_W-1:0] ndrop;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  corr_window_ctrl #(
    .TIME_W (TIME_W),
    .INCR_W (INCR_W),
    .SEQ_W  (SEQ_W),
    .DROP_W (DROP_W)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_enable            (en),
    .i_windowLengthExp   (wexp),
    .o_busy              (busy),
    .o_dpCg              (cg),
    .o_dpT               (t),
    .o_dpZeroCounts      (zc),
    .o_dpWindowLengthExp (dpexp),
    .i_dpCountX          (cx),
    .i_dpCountY          (cy),
    .i_dpCountIsect      (ci),
    .i_dpCountSymdiff    (cs),
    .o_rsltValid         (valid),
    .i_rsltReady         (ready),
    .o_rsltCountX        (rx),
    .o_rsltCountY        (ry),
    .o_rsltCountIsect    (ri),
    .o_rsltCountSymdiff  (rs),
    .o_rsltSeq           (seq)
`ifdef CORR_WINDOW_CTRL_DROPCOUNT_EN
    ,
    .o_nDropped          (ndrop)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_cnt(input int b);
    cx = CNT_W'(b);
    cy = CNT_W'(b + 16);
    ci = CNT_W'(b + 32);
    cs = CNT_W'(b + 48);
  endtask

  task automatic chk_rslt(input string tag, input int s, input int b);
    chk({tag, "_valid"}, 32'(valid), 1);
    chk({tag, "_seq"},   32'(seq),   s);
    chk({tag, "_x"},     32'(rx),    b & 8'h7F);
    chk({tag, "_y"},     32'(ry),    (b + 16) & 8'h7F);
    chk({tag, "_isect"}, 32'(ri),    (b + 32) & 8'h7F);
    chk({tag, "_symd"},  32'(rs),    (b + 48) & 8'h7F);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),  0);
    chk({tag, "_cg"},    32'(cg),    0);
    chk({tag, "_t"},     32'(t),     0);
    chk({tag, "_zc"},    32'(zc),    0);
    chk({tag, "_exp"},   32'(dpexp), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_seq"},   32'(seq),   0);
    chk({tag, "_x"},     32'(rx),    0);
    chk({tag, "_y"},     32'(ry),    0);
    chk({tag, "_isect"}, 32'(ri),    0);
    chk({tag, "_symd"},  32'(rs),    0);
  endtask

  initial begin
    // reset state
    rst = 1'b1; en = 1'b0; ready = 1'b1; wexp = 3'd2; set_cnt(0);
    step(); step();
    chk_zero("rst");
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cg",   32'(cg),   0);

    // exp=2, back-to-back windows, ready high
    en = 1'b1;
    step();
    chk("start_busy", 32'(busy),  1);
    chk("start_cg",   32'(cg),    1);
    chk("start_zc",   32'(zc),    1);
    chk("start_t",    32'(t),     0);
    chk("start_exp",  32'(dpexp), 2);
    chk("start_vld",  32'(valid), 0);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("run_t",  32'(t),  k % 4);
      chk("run_zc", 32'(zc), (k % 4 == 0) ? 1 : 0);
      chk("run_cg", 32'(cg), 1);
      if (k >= 5 && k % 4 == 1) chk_rslt("run_rslt", k / 4 - 1, k - 1);
      else chk("run_vld", 32'(valid), 0);
      set_cnt(k);
    end
    for (int k = 14; k <= 16; k++) begin
      step();
      chk("pre_t",   32'(t),     k % 4);
      chk("pre_vld", 32'(valid), 0);
    end
    set_cnt(0);
    cx = 7'h2A;
    ready = 1'b0;

    // hold for 10 cycles with ready low; two boundary snapshots are dropped
    for (int h = 0; h < 10; h++) begin
      step();
      chk("hold_vld", 32'(valid), 1);
      chk("hold_x",   32'(rx),    32'h2A);
      chk("hold_seq", 32'(seq),   3);
      if (h == 0) set_cnt(8'h11);
      if (h == 9) ready = 1'b1;
    end
    step();
    chk("drain_vld", 32'(valid), 0);
    step();
    chk("drain_t", 32'(t), 0);
    set_cnt(8'h22);
    step();
    chk_rslt("gap", 6, 8'h22);
`ifdef CORR_WINDOW_CTRL_DROPCOUNT_EN
    chk("gap_ndrop", 32'(ndrop), 2);
`endif

    // stop exp=2 run: finish window, FINAL, IDLE
    en = 1'b0;
    step();
    chk("stop_t2", 32'(t), 2);
    step();
    chk("stop_t3",  32'(t),  3);
    chk("stop_cg3", 32'(cg), 1);
    step();
    chk("final_cg",   32'(cg),   0);
    chk("final_zc",   32'(zc),   0);
    chk("final_busy", 32'(busy), 1);
    chk("final_t",    32'(t),    0);
    set_cnt(8'h30);
    step();
    chk("end_busy", 32'(busy), 0);
    chk("end_cg",   32'(cg),   0);
    chk_rslt("end_rslt", 7, 8'h30);

    // exp=3, enable dropped at t=2, exponent change ignored while running
    wexp = 3'd3; en = 1'b1;
    step();
    chk("e3_start_zc",  32'(zc),    1);
    chk("e3_start_exp", 32'(dpexp), 3);
    chk("e3_start_vld", 32'(valid), 0);
`ifdef CORR_WINDOW_CTRL_DROPCOUNT_EN
    chk("e3_ndrop_clr", 32'(ndrop), 0);
`endif
    wexp = 3'd1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("e3_t",   32'(t),     i);
      chk("e3_zc",  32'(zc),    0);
      chk("e3_cg",  32'(cg),    1);
      chk("e3_exp", 32'(dpexp), 3);
      if (i == 2) en = 1'b0;
    end
    step();
    chk("e3_final_cg",   32'(cg),   0);
    chk("e3_final_busy", 32'(busy), 1);
    set_cnt(8'h3C);
    step();
    chk("e3_idle_busy", 32'(busy), 0);
    chk_rslt("e3_rslt", 8, 8'h3C);

    // exp=6 clamps to 4: full 16-cycle window
    wexp = 3'd6; en = 1'b1;
    step();
    chk("e6_exp", 32'(dpexp), 4);
    chk("e6_t0",  32'(t),     0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("e6_t",  32'(t),  i % 16);
      chk("e6_zc", 32'(zc), (i == 16) ? 1 : 0);
    end
    en = 1'b0;
    set_cnt(5);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("e6_stop_len", 32'(n), 17);
    chk_rslt("e6_rslt", 10, 5);

    // exp=0: zero-counts and a snapshot every RUN cycle
    wexp = 3'd0; en = 1'b1;
    step();
    chk("e0_start_zc", 32'(zc),    1);
    chk("e0_exp",      32'(dpexp), 0);
    chk("e0_vld0",     32'(valid), 0);
    set_cnt(8'h40);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("e0_t",  32'(t),  0);
      chk("e0_zc", 32'(zc), 1);
      chk("e0_cg", 32'(cg), 1);
      if (j == 1) chk("e0_vld", 32'(valid), 0);
      else chk_rslt("e0_rslt", 9 + j, 8'h40 + j - 1);
      set_cnt(8'h40 + j);
    end

    // reset while a result is valid
    rst = 1'b1;
    step();
    chk_zero("rst_e0");
    rst = 1'b0;

    // exp=1, ready low across three windows
    wexp = 3'd1; en = 1'b1; ready = 1'b0;
    step();
    chk("e1_start_exp", 32'(dpexp), 1);
    set_cnt(1);
    for (int s = 1; s <= 9; s++) begin
      step();
      chk("e1_t",  32'(t),  s % 2);
      chk("e1_zc", 32'(zc), (s % 2 == 0) ? 1 : 0);
      if (s >= 3 && s <= 7) chk_rslt("e1_held", 0, 8'h0A);
      else if (s == 9) chk_rslt("e1_next", 3, 8'h0B);
      else chk("e1_vld", 32'(valid), 0);
`ifdef CORR_WINDOW_CTRL_DROPCOUNT_EN
      if (s == 7) chk("e1_ndrop", 32'(ndrop), 2);
`endif
      if (s == 2) set_cnt(8'h0A);
      else if (s == 8) set_cnt(8'h0B);
      else set_cnt(8'h70);
      if (s == 7) ready = 1'b1;
    end
    rst = 1'b1;
    step();
    chk("e1_rst_vld",  32'(valid), 0);
    chk("e1_rst_busy", 32'(busy),  0);
    rst = 1'b0;

    // exp=3, reset at t=5 with a result pending, then restart
    wexp = 3'd3; en = 1'b1; ready = 1'b0;
    step();
    chk("r_start_zc", 32'(zc), 1);
    for (int i = 1; i <= 13; i++) begin
      step();
      chk("r_t", 32'(t), i % 8);
      if (i >= 9) chk_rslt("r_pend", 0, 8'h12);
      if (i == 8) set_cnt(8'h12);
      if (i == 9) set_cnt(8'h66);
    end
    rst = 1'b1;
    step();
    chk_zero("rst_t5");
    rst = 1'b0;
    step();
    chk("re_busy", 32'(busy), 1);
    chk("re_zc",   32'(zc),   1);
    chk("re_cg",   32'(cg),   1);
    chk("re_t",    32'(t),    0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("re_t", 32'(t), i % 8);
      if (i == 8) set_cnt(8'h21);
    end
    step();
    chk_rslt("re_rslt", 0, 8'h21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
